// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_pkg
// Description : Shared types for the data-memory responder: word and address
//               types, the channel latency counter width and the channel FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    localparam int DATA_WIDTH                = 32;
    localparam int DATA_MEMORY_ADDRESS_WIDTH = 16;

    // Wide enough for the largest legal LATENCY-1 (14)
    localparam int CNT_WIDTH = 4;

    typedef logic [DATA_WIDTH-1:0]                data_t;
    typedef logic [DATA_MEMORY_ADDRESS_WIDTH-1:0] data_memory_address_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_resp_channel.sv
`default_nettype none
// ============================================================================
// Module      : mem_resp_channel
// Description : One direction of one memory channel. Accepts a request in
//               IDLE, counts out the fixed latency and flags the cycle in
//               which the response register must be loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_resp_channel
    import data_mem_responder_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic valid,
    output logic accept,
    output logic load
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_init = CNT_WIDTH'(LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    mem_resp_state_t      r_state;
    logic [CNT_WIDTH-1:0] r_cnt;

    // accept: request taken on this edge; load: next cycle is the RESP cycle
    always_comb begin
        accept = 1'b0;
        load   = 1'b0;
        if (!reset) begin
            accept = (r_state == IDLE) && valid;
            load   = (accept && (c_cnt_init == '0)) ||
                     ((r_state == WAIT) && (r_cnt == c_cnt_one));
        end
    end

    // Channel FSM and latency counter; valid is only looked at in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid) begin
                        r_cnt   <= c_cnt_init;
                        r_state <= (c_cnt_init == '0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Fixed-latency multi-channel responder for the data-memory
//               bus. Holds the word array, resolves same-edge writes (backdoor
//               first, then lowest channel), range-checks every access and
//               keeps a sticky out-of-range flag.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int DEPTH_WORDS  = 1024,
    parameter int LATENCY      = 2
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic [NUM_CHANNELS-1:0]                                mem_read_valid,
    input  logic [NUM_CHANNELS-1:0][DATA_MEMORY_ADDRESS_WIDTH-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]                                mem_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]                mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                                mem_write_valid,
    input  logic [NUM_CHANNELS-1:0][DATA_MEMORY_ADDRESS_WIDTH-1:0] mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]                mem_write_data,
    output logic [NUM_CHANNELS-1:0]                                mem_write_ready,
    input  logic                                                   init_we,
    input  logic [DATA_MEMORY_ADDRESS_WIDTH-1:0]                   init_addr,
    input  logic [DATA_WIDTH-1:0]                                  init_data,
    output logic                                                   oob_error
);

    localparam int c_idx_width = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // One extra bit so the depth itself is representable next to the address
    localparam logic [DATA_MEMORY_ADDRESS_WIDTH:0] c_depth =
        (DATA_MEMORY_ADDRESS_WIDTH + 1)'(DEPTH_WORDS);

    data_t r_mem [DEPTH_WORDS];

    logic [NUM_CHANNELS-1:0]                  w_rd_accept;
    logic [NUM_CHANNELS-1:0]                  w_rd_load;
    logic [NUM_CHANNELS-1:0]                  w_rd_in_range;
    logic [NUM_CHANNELS-1:0]                  w_wr_accept;
    logic [NUM_CHANNELS-1:0]                  w_wr_load;
    logic [NUM_CHANNELS-1:0]                  w_wr_in_range;
    logic [NUM_CHANNELS-1:0][c_idx_width-1:0] w_rd_index;
    logic [NUM_CHANNELS-1:0][c_idx_width-1:0] w_wr_index;
    logic                                     w_init_in_range;
    logic [c_idx_width-1:0]                   w_init_index;

    assign w_init_in_range = {1'b0, init_addr} < c_depth;
    assign w_init_index    = init_addr[c_idx_width-1:0];

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
        data_t w_rd_word;
        data_t r_rd_capture;
        data_t r_rd_data;
        logic  r_rd_ready;
        logic  r_wr_ready;

        // Range check uses the full address; only the low bits index the array
        assign w_rd_in_range[ch] = {1'b0, mem_read_address[ch]} < c_depth;
        assign w_wr_in_range[ch] = {1'b0, mem_write_address[ch]} < c_depth;
        assign w_rd_index[ch]    = mem_read_address[ch][c_idx_width-1:0];
        assign w_wr_index[ch]    = mem_write_address[ch][c_idx_width-1:0];
        assign w_rd_word         = w_rd_in_range[ch] ? r_mem[w_rd_index[ch]] : '0;

        mem_resp_channel #(
            .LATENCY (LATENCY)
        ) u_rd (
            .clk    (clk),
            .reset  (reset),
            .valid  (mem_read_valid[ch]),
            .accept (w_rd_accept[ch]),
            .load   (w_rd_load[ch])
        );

        mem_resp_channel #(
            .LATENCY (LATENCY)
        ) u_wr (
            .clk    (clk),
            .reset  (reset),
            .valid  (mem_write_valid[ch]),
            .accept (w_wr_accept[ch]),
            .load   (w_wr_load[ch])
        );

        // Read word is captured at accept and moved to the output on entering RESP,
        // so the previous response stays visible until the next ready pulse
        always_ff @(posedge clk) begin
            if (reset) begin
                r_rd_capture <= '0;
                r_rd_data    <= '0;
                r_rd_ready   <= 1'b0;
                r_wr_ready   <= 1'b0;
            end else begin
                r_rd_ready <= w_rd_load[ch];
                r_wr_ready <= w_wr_load[ch];
                if (w_rd_accept[ch]) begin
                    r_rd_capture <= w_rd_word;
                end
                if (w_rd_load[ch]) begin
                    r_rd_data <= w_rd_accept[ch] ? w_rd_word : r_rd_capture;
                end
            end
        end

        assign mem_read_data[ch]   = r_rd_data;
        assign mem_read_ready[ch]  = r_rd_ready;
        assign mem_write_ready[ch] = r_wr_ready;
    end

    // Array update: later assignments win, so iterate high-to-low channel and
    // apply the backdoor last
    always_ff @(posedge clk) begin
        for (int ch = NUM_CHANNELS - 1; ch >= 0; ch--) begin
            if (w_wr_accept[ch] && w_wr_in_range[ch]) begin
                r_mem[w_wr_index[ch]] <= mem_write_data[ch];
            end
        end
        if (init_we && !reset && w_init_in_range) begin
            r_mem[w_init_index] <= init_data;
        end
    end

    // Sticky flag for any accepted out-of-range access
    always_ff @(posedge clk) begin
        if (reset) begin
            oob_error <= 1'b0;
        end else if ((|(w_rd_accept & ~w_rd_in_range)) ||
                     (|(w_wr_accept & ~w_wr_in_range))) begin
            oob_error <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Scoreboard bench for data_mem_responder. Stimulus pushes the
//               expected ready cycle and data per channel; a negedge monitor
//               pops and compares whenever a ready pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int NCH   = 8;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int AW    = 16;
    localparam int DW    = 32;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [NCH-1:0]         mem_read_valid;
    logic [NCH-1:0][AW-1:0] mem_read_address;
    logic [NCH-1:0]         mem_read_ready;
    logic [NCH-1:0][DW-1:0] mem_read_data;
    logic [NCH-1:0]         mem_write_valid;
    logic [NCH-1:0][AW-1:0] mem_write_address;
    logic [NCH-1:0][DW-1:0] mem_write_data;
    logic [NCH-1:0]         mem_write_ready;
    logic                   init_we;
    logic [AW-1:0]          init_addr;
    logic [DW-1:0]          init_data;
    logic                   oob_error;

    logic                   d3_rst;
    logic [NCH-1:0]         d3_rv;
    logic [NCH-1:0][AW-1:0] d3_ra;
    logic [NCH-1:0]         d3_rr;
    logic [NCH-1:0][DW-1:0] d3_rd;
    logic [NCH-1:0]         d3_wv;
    logic [NCH-1:0][AW-1:0] d3_wa;
    logic [NCH-1:0][DW-1:0] d3_wd;
    logic [NCH-1:0]         d3_wr;
    logic                   d3_iwe;
    logic [AW-1:0]          d3_ia;
    logic [DW-1:0]          d3_id;
    logic                   d3_oob;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t rd_q [NCH][$];
    int   wr_q [NCH][$];
    logic [DW-1:0] pre [8];

    data_mem_responder #(
        .NUM_CHANNELS (NCH),
        .DEPTH_WORDS  (DEPTH),
        .LATENCY      (LAT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_read_valid    (mem_read_valid),
        .mem_read_address  (mem_read_address),
        .mem_read_ready    (mem_read_ready),
        .mem_read_data     (mem_read_data),
        .mem_write_valid   (mem_write_valid),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .mem_write_ready   (mem_write_ready),
        .init_we           (init_we),
        .init_addr         (init_addr),
        .init_data         (init_data),
        .oob_error         (oob_error)
    );

    data_mem_responder #(
        .NUM_CHANNELS (NCH),
        .DEPTH_WORDS  (DEPTH),
        .LATENCY      (3)
    ) dut3 (
        .clk               (clk),
        .reset             (d3_rst),
        .mem_read_valid    (d3_rv),
        .mem_read_address  (d3_ra),
        .mem_read_ready    (d3_rr),
        .mem_read_data     (d3_rd),
        .mem_write_valid   (d3_wv),
        .mem_write_address (d3_wa),
        .mem_write_data    (d3_wd),
        .mem_write_ready   (d3_wr),
        .init_we           (d3_iwe),
        .init_addr         (d3_ia),
        .init_data         (d3_id),
        .oob_error         (d3_oob)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest expectation
    always @(negedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (mem_read_ready[ch] === 1'b1) begin
                check($sformatf("rd%0d_expected", ch), 64'(rd_q[ch].size() > 0), 64'd1);
                if (rd_q[ch].size() > 0) begin
                    exp_t e;
                    e = rd_q[ch].pop_front();
                    check($sformatf("rd%0d_cycle", ch), 64'(cyc), 64'(e.cyc));
                    check($sformatf("rd%0d_data", ch), 64'(mem_read_data[ch]), 64'(e.data));
                end
            end
            if (mem_write_ready[ch] === 1'b1) begin
                check($sformatf("wr%0d_expected", ch), 64'(wr_q[ch].size() > 0), 64'd1);
                if (wr_q[ch].size() > 0) begin
                    int ec;
                    ec = wr_q[ch].pop_front();
                    check($sformatf("wr%0d_cycle", ch), 64'(cyc), 64'(ec));
                end
            end
        end
    end

    task automatic preload(input int a, input logic [DW-1:0] d);
        init_we   = 1'b1;
        init_addr = AW'(a);
        init_data = d;
        @(posedge clk); #1;
        init_we   = 1'b0;
    endtask

    task automatic rd_start(input int ch, input int a, input logic [DW-1:0] e);
        mem_read_valid[ch]   = 1'b1;
        mem_read_address[ch] = AW'(a);
        rd_q[ch].push_back('{cyc: cyc + LAT, data: e});
    endtask

    task automatic wr_start(input int ch, input int a, input logic [DW-1:0] d);
        mem_write_valid[ch]   = 1'b1;
        mem_write_address[ch] = AW'(a);
        mem_write_data[ch]    = d;
        wr_q[ch].push_back(cyc + LAT);
    endtask

    // Hold valids until each channel's ready is seen, then drop on that edge
    task automatic run_txn();
        int n;
        logic [NCH-1:0] rr;
        logic [NCH-1:0] wr;
        n = 0;
        while ((mem_read_valid != '0 || mem_write_valid != '0) && n < 40) begin
            @(negedge clk);
            rr = mem_read_ready;
            wr = mem_write_ready;
            @(posedge clk); #1;
            init_we = 1'b0;
            mem_read_valid  = mem_read_valid & ~rr;
            mem_write_valid = mem_write_valid & ~wr;
            n++;
        end
        check("txn_completed", 64'(n < 40), 64'd1);
        mem_read_valid  = '0;
        mem_write_valid = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   k;
        logic got;
        int   pend;

        pre[0] = 32'h1111_0000; pre[1] = 32'h2222_0001;
        pre[2] = 32'h3333_0002; pre[3] = 32'h4444_0003;
        pre[4] = 32'h5555_0004; pre[5] = 32'hDEAD_BEEF;
        pre[6] = 32'h7777_0006; pre[7] = 32'h8888_0007;

        reset = 1'b1; d3_rst = 1'b1;
        mem_read_valid = '0; mem_read_address = '0;
        mem_write_valid = '0; mem_write_address = '0; mem_write_data = '0;
        init_we = 1'b0; init_addr = '0; init_data = '0;
        d3_rv = '0; d3_ra = '0; d3_wv = '0; d3_wa = '0; d3_wd = '0;
        d3_iwe = 1'b0; d3_ia = '0; d3_id = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; d3_rst = 1'b0;

        for (int i = 0; i < 8; i++) preload(i, pre[i]);
        preload(9,  32'h0000_5555);
        preload(20, 32'h0000_7777);
        preload(21, 32'h0000_0001);
        preload(40, 32'h0000_1111);

        // Backdoor write during reset must be ignored; array survives reset
        reset = 1'b1; init_we = 1'b1; init_addr = AW'(40); init_data = 32'h0000_9999;
        repeat (2) @(posedge clk);
        #1;
        init_we = 1'b0; reset = 1'b0;
        @(negedge clk);
        check("rst_read_ready",  64'(mem_read_ready),  64'd0);
        check("rst_write_ready", 64'(mem_write_ready), 64'd0);
        check("rst_read_data",   64'(mem_read_data != '0), 64'd0);
        check("rst_oob_error",   64'(oob_error), 64'd0);
        @(posedge clk); #1;

        // Single read
        rd_start(0, 5, 32'hDEAD_BEEF);
        run_txn();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rd_data_held", 64'(mem_read_data[0]), 64'hDEAD_BEEF);
        @(posedge clk); #1;

        rd_start(1, 40, 32'h0000_1111);
        run_txn();

        // All channels in parallel
        for (int i = 0; i < NCH; i++) rd_start(i, i, pre[i]);
        run_txn();

        // Write then read; same-edge read sees the old value
        wr_start(3, 9, 32'h0000_1234);
        rd_start(4, 9, 32'h0000_5555);
        run_txn();
        rd_start(2, 9, 32'h0000_1234);
        run_txn();

        // Same-address collision: lowest channel wins
        wr_start(1, 20, 32'h0000_AAAA);
        wr_start(6, 20, 32'h0000_BBBB);
        run_txn();
        rd_start(0, 20, 32'h0000_AAAA);
        run_txn();

        // Backdoor beats a channel write on the same edge
        wr_start(5, 21, 32'h0000_DDDD);
        init_we = 1'b1; init_addr = AW'(21); init_data = 32'h0000_CCCC;
        run_txn();
        rd_start(5, 21, 32'h0000_CCCC);
        run_txn();

        // Out of range read and write
        @(negedge clk);
        check("oob_before", 64'(oob_error), 64'd0);
        @(posedge clk); #1;
        rd_start(7, DEPTH + 3, 32'h0);
        run_txn();
        @(negedge clk);
        check("oob_after_read", 64'(oob_error), 64'd1);
        @(posedge clk); #1;
        wr_start(2, DEPTH + 3, 32'hFFFF_FFFF);
        run_txn();
        rd_start(1, 3, pre[3]);
        run_txn();
        @(negedge clk);
        check("oob_sticky", 64'(oob_error), 64'd1);
        @(posedge clk); #1;

        // Reset mid-flight on the LATENCY=3 instance
        d3_iwe = 1'b1; d3_ia = AW'(5); d3_id = 32'h0BAD_F00D;
        @(posedge clk); #1;
        d3_iwe = 1'b0;
        d3_rv[0] = 1'b1; d3_ra[0] = AW'(5);
        @(posedge clk); #1;
        d3_rv = '0; d3_rst = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk); seen = seen | (|d3_rr);
            @(posedge clk); #1;
        end
        d3_rst = 1'b0;
        repeat (4) begin
            @(negedge clk); seen = seen | (|d3_rr);
            @(posedge clk); #1;
        end
        check("rst_mid_no_ready", 64'(seen), 64'd0);
        @(negedge clk);
        check("rst_mid_read_data", 64'(d3_rd != '0), 64'd0);
        check("rst_mid_oob", 64'(d3_oob), 64'd0);
        @(posedge clk); #1;
        d3_rv[0] = 1'b1; d3_ra[0] = AW'(5);
        k = 0; got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clk);
            if (d3_rr[0] === 1'b1) got = 1'b1;
            else begin
                @(posedge clk); #1;
                k++;
            end
        end
        check("rst_mid_new_latency", 64'(k), 64'd3);
        check("rst_mid_new_data", 64'(d3_rd[0]), 64'h0BAD_F00D);
        @(posedge clk); #1;
        d3_rv = '0;

        repeat (4) @(posedge clk);
        #1;
        pend = 0;
        for (int i = 0; i < NCH; i++) pend += rd_q[i].size() + wr_q[i].size();
        check("pending_responses", 64'(pend), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
